kmeans_ram_arbiter: RTL
=======================

KMEANS_RAM_ARBITER -- requirements
Module: kmeans_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, sets the pixel address width.
REQ-002 Parameter DATA_W, default 12, sets the sample/pixel data width.
REQ-003 Parameter PIX_MAX, default 307200, is the first out-of-range address (640x480 frame).
REQ-004 Parameter MAX_BURST, default 16, is the maximum number of consecutive acks to one owner while the other requester waits.
REQ-005 KmeansArb_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 KmeansArb_rst  in  1  asynchronous, active-low reset.
REQ-007 reqN  in  1  (N=0,1) access request; port 0 is the initial-centroid writer, port 1 is the k-means iterator.
REQ-008 weN  in  1  1=write, 0=read; held stable with addrN/wdataN until ackN.
REQ-009 addrN  in  ADDR_W  pixel address.
REQ-010 wdataN  in  DATA_W  write data.
REQ-011 ackN  out  1  one-cycle pulse; the access is accepted this cycle.
REQ-012 rvalidN  out  1  one-cycle pulse; rdataN holds read data for port N.
REQ-013 rdataN  out  DATA_W  read data; holds its value until the next rvalidN.
REQ-014 gnt  out  2  one-hot current owner (bit N = port N), 00 in IDLE.
REQ-015 ToBlockRam_clka  out  1  equals KmeansArb_clk.
REQ-016 ADDRA  out  ADDR_W  registered BRAM port-A address.
REQ-017 dina  out  DATA_W  registered BRAM write data.
REQ-018 wea  out  1  registered BRAM write enable.
REQ-019 ena  out  1  registered BRAM port enable.
REQ-020 douta  in  DATA_W  BRAM read data, valid one cycle after the cycle in which ena=1.
REQ-021 err  out  1  sticky out-of-range access flag.

Function
REQ-022 FSM states IDLE, OWN0, OWN1; gnt encodes the state.
REQ-023 IDLE: no ack; next state OWN0/OWN1 if only that req is high; if both are high, the port not last served wins.
REQ-024 OWNx with reqx=1: ackx=1 combinationally in that cycle and the burst counter increments.
REQ-025 OWNx with reqx=0: no ack; next state OWNy if reqy=1, else IDLE; the counter clears.
REQ-026 On an ack that brings the counter to MAX_BURST: if reqy=1, next state is OWNy; else the counter clears and OWNx continues.
REQ-027 Each owner change updates last_served and clears the counter.
REQ-028 Ack in cycle N -> ena=1, ADDRA/dina/wea driven in cycle N+1 -> douta sampled into rdataN with rvalidN=1 in cycle N+3 (reads only).
REQ-029 ena, wea = 0 in every cycle without an accepted in-range access; ADDRA/dina hold their last values.
REQ-030 Writes produce no rvalid.
REQ-031 A 2-stage tag pipeline (valid, port, dropped) tracks each read; back-to-back reads on consecutive cycles are supported.
REQ-032 Out-of-range (addr >= PIX_MAX): ack is still given, ena/wea stay 0 for that slot, and err sets; a read still returns rvalid at N+3 with rdata=0.
REQ-033 err clears only on reset.
REQ-034 reqN deasserted without ack is legal and drops nothing.

Reset
REQ-035 While KmeansArb_rst=0: state IDLE, gnt=00, counter=0, last_served=1 (port 0 favoured first), tag pipeline flushed, and ack, rvalid, ena, wea, err, ADDRA, dina, rdata all 0.
REQ-036 Reset asserted mid-burst or with reads in flight discards pending rvalids; no rvalid occurs after release for pre-reset accesses.
REQ-037 After reset release, the first ack occurs no earlier than the second rising edge after a req is seen in IDLE.

Verification
REQ-038 req0=1 alone, we0=0, addr0=5, douta=0xABC in the cycle after ena: gnt=01 one cycle after req; ack0 at N; ena=1, ADDRA=5 at N+1; rvalid0=1, rdata0=0xABC at N+3.
REQ-039 req0 and req1 both high from IDLE after reset: port 0 owns first; with both held, 16 ack0 pulses, then gnt=10 the next cycle and 16 ack1 pulses, alternating.
REQ-040 Port 1 writes with addr1=307200 then 307199: first ack1 gives ena=0 and err=1 (sticky); second gives ena=1, wea=1, ADDRA=307199.
REQ-041 Port 1 reads 4 consecutive addresses 0..3: 4 rvalid1 pulses on consecutive cycles in order, starting 3 cycles after the first ack1.
REQ-042 Reset pulsed low one cycle after 2 read acks: all outputs 0 immediately; no rvalid in the 5 cycles after release with req low.
REQ-043 Port 0 owns with req0 held and req1 never asserted: ack0 continuous beyond 16 acks, and gnt stays 01.

Source files
------------

// File: rtl/kmeans_ram_arbiter.sv
// kmeans_ram_arbiter: two-port burst-limited arbiter in front of a single-port block RAM.
// Rev 1.0 -- initial release.
`default_nettype none

module kmeans_ram_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 12,
  parameter int PIX_MAX   = 307200,
  parameter int MAX_BURST = 16
) (
  input  logic              KmeansArb_clk,
  input  logic              KmeansArb_rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              ToBlockRam_clka,
  output logic [ADDR_W-1:0] ADDRA,
  output logic [DATA_W-1:0] dina,
  output logic              wea,
  output logic              ena,
  input  logic [DATA_W-1:0] douta,
  output logic              err
);

  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W:0]   PIX_LIM  = (ADDR_W + 1)'(PIX_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;

  logic              ena_q, wea_q, err_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dina_q;
  logic              t1_v_q, t1_p_q, t1_d_q;
  logic              t2_v_q, t2_p_q, t2_d_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              acc_v_w, acc_p_w, acc_we_w, acc_oor_w, acc_ok_w;
  logic [ADDR_W-1:0] acc_addr_w;
  logic [DATA_W-1:0] acc_wdata_w;

  // Acks are combinational so a held request is accepted in every owned cycle.
  assign ack0 = (state_q == OWN0) && req0;
  assign ack1 = (state_q == OWN1) && req1;

  assign acc_v_w     = ack0 | ack1;
  assign acc_p_w     = ack1;
  assign acc_we_w    = acc_p_w ? we1    : we0;
  assign acc_addr_w  = acc_p_w ? addr1  : addr0;
  assign acc_wdata_w = acc_p_w ? wdata1 : wdata0;
  assign acc_oor_w   = ({1'b0, acc_addr_w} >= PIX_LIM);
  assign acc_ok_w    = acc_v_w && !acc_oor_w;

  always_ff @(posedge KmeansArb_clk or negedge KmeansArb_rst) begin
    if (!KmeansArb_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req0 && (!req1 || last_q)) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
          end
        end
        OWN0: begin
          if (req0) begin
            if (cnt_q == LAST_CNT) begin
              cnt_q <= '0;
              if (req1) begin
                state_q <= OWN1;
                last_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
            if (req1) begin
              state_q <= OWN1;
              last_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OWN1: begin
          if (req1) begin
            if (cnt_q == LAST_CNT) begin
              cnt_q <= '0;
              if (req0) begin
                state_q <= OWN0;
                last_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
            if (req0) begin
              state_q <= OWN0;
              last_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Tag stages line up with the RAM latency; dropped reads return zero.
  always_ff @(posedge KmeansArb_clk or negedge KmeansArb_rst) begin
    if (!KmeansArb_rst) begin
      ena_q     <= 1'b0;
      wea_q     <= 1'b0;
      err_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      t1_v_q    <= 1'b0;
      t1_p_q    <= 1'b0;
      t1_d_q    <= 1'b0;
      t2_v_q    <= 1'b0;
      t2_p_q    <= 1'b0;
      t2_d_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      ena_q <= acc_ok_w;
      wea_q <= acc_ok_w && acc_we_w;
      if (acc_ok_w) begin
        addra_q <= acc_addr_w;
        dina_q  <= acc_wdata_w;
      end
      if (acc_v_w && acc_oor_w) err_q <= 1'b1;

      t1_v_q <= acc_v_w && !acc_we_w;
      t1_p_q <= acc_p_w;
      t1_d_q <= acc_oor_w;
      t2_v_q <= t1_v_q;
      t2_p_q <= t1_p_q;
      t2_d_q <= t1_d_q;

      rvalid0_q <= t2_v_q && !t2_p_q;
      rvalid1_q <= t2_v_q && t2_p_q;
      if (t2_v_q && !t2_p_q) rdata0_q <= t2_d_q ? '0 : douta;
      if (t2_v_q && t2_p_q)  rdata1_q <= t2_d_q ? '0 : douta;
    end
  end

  assign gnt             = state_q;
  assign ToBlockRam_clka = KmeansArb_clk;
  assign ADDRA           = addra_q;
  assign dina            = dina_q;
  assign wea             = wea_q;
  assign ena             = ena_q;
  assign err             = err_q;
  assign rvalid0         = rvalid0_q;
  assign rvalid1         = rvalid1_q;
  assign rdata0          = rdata0_q;
  assign rdata1          = rdata1_q;

endmodule

`default_nettype wire
